deserializer: RTL

Serial-to-parallel receiver; the receive end of the team's serial link, paired with the existing down-counter-driven serializer. Samples one bit per qualified clock, frames words with a start strobe, and counts bits with an internal down-counter. Delivers each completed word through a one-entry valid/ready output register. Reports overrun and framing errors.

---
 rtl/serdes_pkg.sv | 13 +
 rtl/deserializer_if.sv | 22 ++
 rtl/deserializer_bit_down_counter.sv | 27 ++
 rtl/deserializer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serial link (serializer and deserializer).
// Holds the receive FSM state type and the bit-counter width function.
package serdes_pkg;

    typedef enum logic {IDLE, RECV} deser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/deserializer_if.sv
// Serial-in / word-out bus of the deserializer.
// master = link driver plus word consumer; slave = deserializer.
interface deserializer_if #(parameter int WIDTH = 8);

    logic             ser_in;
    logic             ser_valid;
    logic             ser_start;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output ser_in, ser_valid, ser_start, data_ready,
        input  data_out, data_valid
    );

    modport slave (
        input  ser_in, ser_valid, ser_start, data_ready,
        output data_out, data_valid
    );

endinterface

// File: rtl/deserializer_bit_down_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement.
// Latency 1 clock; no backpressure; saturates at zero.
module bit_down_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver framed by ser_start; one-entry valid/ready output register.
// Latency 1 clock from last bit to data_valid; a completed word is dropped (overrun) when the register is full.
module deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       resetN,
    deserializer_if.slave              bus,
    output logic                       busy,
    output logic [cnt_width(WIDTH)-1:0] bits_left,
    output logic                       overrun,
    output logic                       frame_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

    deser_state_t     state, next_state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             frame_err_q;

    logic             cnt_load;
    logic [CW-1:0]    cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             sh_fresh;
    logic             sh_shift;
    logic             word_done;
    logic             ferr_d;
    logic             out_free;

    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], bus.ser_in}
                               : {bus.ser_in, shreg[WIDTH-1:1]};
    assign fresh   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.ser_in}
                               : {bus.ser_in, {(WIDTH-1){1'b0}}};

    bit_down_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .resetN   (resetN),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (bits_left),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        sh_fresh   = 1'b0;
        sh_shift   = 1'b0;
        word_done  = 1'b0;
        ferr_d     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ser_valid && bus.ser_start) begin
                    sh_fresh   = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = LOAD_VAL;
                    next_state = RECV;
                end
            end
            RECV: begin
                // A zero count in RECV cannot arise from legal sequencing; fall back to IDLE.
                if (cnt_zero) begin
                    next_state = IDLE;
                end else if (bus.ser_valid) begin
                    if (bus.ser_start) begin
                        ferr_d   = 1'b1;
                        sh_fresh = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = LOAD_VAL;
                    end else begin
                        sh_shift = 1'b1;
                        if (bits_left == CW'(1)) begin
                            word_done  = 1'b1;
                            cnt_load   = 1'b1;
                            cnt_val    = '0;
                            next_state = IDLE;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shreg <= '0;
        end else if (sh_fresh) begin
            shreg <= fresh;
        end else if (sh_shift) begin
            shreg <= shifted;
        end
    end

    // A consumer handshake on the completing edge frees the slot for the new word.
    assign out_free = !valid_q || bus.data_ready;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= word_done && !out_free;
            frame_err_q <= ferr_d;
            if (word_done && out_free) begin
                data_q  <= shifted;
                valid_q <= 1'b1;
            end else if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign busy           = (state == RECV);
    assign overrun        = overrun_q;
    assign frame_err      = frame_err_q;

endmodule
